// File: rtl/conv_mdc_kernel_ctrl_pkg.sv
// Shared types and constants for the conv_mdc kernel job controller and its
// adapter link.
package conv_mdc_kernel_ctrl_pkg;

    localparam int unsigned CONV_MDC_TIMEOUT_CYC = 4096;

    typedef struct packed {
        logic start;
    } ctrl_kernel_adapter_t;

    typedef struct packed {
        logic done;
        logic ready;
        logic idle;
    } flags_kernel_adapter_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STRM,
        START,
        COMPUTE,
        DRAIN,
        DONE
    } kernel_ctrl_state_t;

    // States in which the kernel is expected to make progress.
    function automatic logic is_watched_state(kernel_ctrl_state_t s);
        return (s == COMPUTE) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/conv_mdc_kernel_ctrl_if.sv
// Controller <-> kernel adapter link: start command out, per-output flags back.
interface conv_mdc_kernel_ctrl_if;
    import conv_mdc_kernel_ctrl_pkg::*;

    ctrl_kernel_adapter_t  ctrl;
    flags_kernel_adapter_t flags;

    modport master (output ctrl, input flags);
    modport slave  (input ctrl, output flags);

endinterface

// File: rtl/conv_mdc_kernel_ctrl_watchdog.sv
// Stall watchdog: counts cycles since the last load and flags expiry once
// TIMEOUT_CYC cycles have passed without a reload. TIMEOUT_CYC=0 disables it.
module conv_mdc_watchdog #(
    parameter int unsigned TO_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYC);

    logic [TO_WIDTH-1:0] r_cnt;

    // Loading to 1 makes the count include the current cycle, so expiry lands
    // exactly TIMEOUT_CYC cycles after the reload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= TO_WIDTH'(1);
        end else if (inc_i && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + TO_WIDTH'(1);
        end
    end

    generate
        if (TIMEOUT_CYC == 0) begin : g_disabled
            logic w_unused_cnt;
            assign w_unused_cnt = ^r_cnt;
            assign expire_o     = 1'b0;
        end else begin : g_enabled
            assign expire_o = inc_i && (r_cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/conv_mdc_kernel_ctrl.sv
// Job-level initiator for the conv_mdc kernel adapter: waits for the streamers,
// fires one start, counts done pulses against the job length, aborts on stall.
module conv_mdc_kernel_ctrl
    import conv_mdc_kernel_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYC = CONV_MDC_TIMEOUT_CYC,
    parameter int unsigned TO_WIDTH    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   job_start_i,
    input  logic [CNT_WIDTH-1:0]   n_outputs_i,
    input  logic                   streamer_ready_i,
    conv_mdc_kernel_ctrl_if.master kernel_if,
    output logic                   busy_o,
    output logic                   job_done_o,
    output logic                   err_timeout_o,
    output logic [CNT_WIDTH-1:0]   out_cnt_o
);

    kernel_ctrl_state_t r_state;
    kernel_ctrl_state_t w_state_next;

    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_out_cnt;
    logic                 r_err;

    logic                 w_srst;
    logic                 w_done;
    logic                 w_idle;
    logic                 w_watched;
    logic                 w_expire;
    logic                 w_abort;
    logic                 w_last_done;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_start;
    logic                 w_unused_ready;

    assign w_srst         = rst_i | clear_i;
    assign w_done         = kernel_if.flags.done;
    assign w_idle         = kernel_if.flags.idle;
    assign w_unused_ready = kernel_if.flags.ready;
    assign w_watched      = is_watched_state(r_state);

    assign w_cnt_inc   = (&r_out_cnt) ? r_out_cnt : r_out_cnt + CNT_WIDTH'(1);
    assign w_last_done = w_done && (w_cnt_inc == r_len);

    // A normal DRAIN exit wins over a coincident expiry.
    assign w_abort = w_expire && !((r_state == DRAIN) && w_idle);

    // COMPUTE is only entered from START and DRAIN only on a done, so reloading
    // outside the watched states and on every done covers both state entries.
    conv_mdc_watchdog #(
        .TO_WIDTH    (TO_WIDTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (w_srst),
        .load_i   (!w_watched || w_done),
        .inc_i    (w_watched && !w_done),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i) begin
        if (w_srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (job_start_i) begin
                    w_state_next = (n_outputs_i == '0) ? DONE : WAIT_STRM;
                end
            end
            WAIT_STRM: begin
                if (streamer_ready_i) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_state_next = COMPUTE;
            end
            COMPUTE: begin
                if (w_last_done) begin
                    w_state_next = DRAIN;
                end else if (w_abort) begin
                    w_state_next = DONE;
                end
            end
            DRAIN: begin
                if (w_idle || w_abort) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_start    = (r_state == START);
        busy_o     = (r_state != IDLE);
        job_done_o = (r_state == DONE);
    end

    assign kernel_if.ctrl.start = w_start;

    always_ff @(posedge clk_i) begin
        if (w_srst) begin
            r_len     <= '0;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == IDLE) && job_start_i) begin
                r_len     <= n_outputs_i;
                r_out_cnt <= '0;
                r_err     <= 1'b0;
            end else if (w_watched && w_done) begin
                r_out_cnt <= w_cnt_inc;
            end
            if (w_watched && w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_timeout_o = r_err;
    assign out_cnt_o     = r_out_cnt;

endmodule
